idli_sync_m: RTL and testbench
==============================

Name: idli_sync_m

Overview:
- Core sync/control block. Owns the slice counter (currently a free-running 2-bit counter in the top level) and replaces it with a parametrised sequencer.
- Generalised for any data width and slice width. Adds three behaviours the free-running counter lacks:
  - post-reset memory warm-up;
  - word-boundary stall;
  - redirect flush with a per-stage valid pipeline.
- Sits between the top level and the SQI and decode blocks; every slice-serial unit takes o_sync_ctr from here.

Parameters:
DATA_W, 16, architectural word width in bits.
SLICE_W, 4, bits per slice; DATA_W must be an integer multiple.
INIT_WORDS, 2, whole words spent in INIT after reset (SQI command/address warm-up); minimum 1.
FLUSH_WORDS, 1, whole words spent in FLUSH after an accepted redirect; minimum 1.
NUM_STAGES, 2, depth of the stage-valid shift register; minimum 1.

Ports:
i_sync_gck  in  1  core clock.
i_sync_rst_n  in  1  reset, asynchronous, active-low.
i_sync_stall  in  1  stall request, level-sensitive.
i_sync_redirect  in  1  redirect request, single-cycle pulse.
i_sync_instr_vld  in  1  SQI has a complete instruction this word.
o_sync_ctr  out  CTR_W  slice index, where SLICES = DATA_W/SLICE_W and CTR_W = $clog2(SLICES).
o_sync_first  out  1  ctr == 0.
o_sync_last  out  1  ctr == SLICES-1.
o_sync_word_end  out  1  last slice and the counter is advancing.
o_sync_run  out  1  state is RUN.
o_sync_sqi_redirect  out  1  one-cycle pulse to SQI on the first slice of FLUSH.
o_sync_stage_vld  out  NUM_STAGES  per-stage instruction valid; bit 0 is the youngest stage.

Behaviour:
- Clock and reset: one clock, i_sync_gck. Reset i_sync_rst_n is asynchronous, active-low.
- Reset values:
  - state = INIT, ctr = 0, init/flush word count = 0, redirect-pending = 0, stage_vld = 0.
  - Therefore o_sync_first = 1, o_sync_last = 0 (SLICES > 1), o_sync_word_end = 0, o_sync_run = 0, o_sync_sqi_redirect = 0.
  - Asserting reset mid-word forces the full reset state immediately; no partial word survives.
- Counter:
  - adv = (state != STALL) || !i_sync_stall.
  - When adv, ctr <= (ctr == SLICES-1) ? 0 : ctr + 1; otherwise ctr holds.
  - Counter wraps modulo SLICES. first, last and word_end are combinational from registered ctr/state.
- State machine (sync_state_t: INIT, RUN, STALL, FLUSH):
  - INIT: the counter runs. Each word_end increments the word count. On the INIT_WORDS-th word_end, go to FLUSH if redirect-pending, otherwise RUN.
  - RUN: at word_end, priority is redirect-pending (or i_sync_redirect this cycle) → FLUSH; else i_sync_stall → STALL; else stay in RUN. Stall is only sampled on the last slice.
  - STALL: ctr holds at 0. On a cycle with i_sync_stall = 0, ctr becomes 1 next cycle and state returns to RUN, so the release cycle counts as slice 0. A redirect in STALL is latched as pending and acted on at the next word_end.
  - FLUSH:
    - On entry, word count = 0 and redirect-pending is cleared.
    - o_sync_sqi_redirect pulses on slice 0 of the first flush word.
    - Each word_end increments the word count; at FLUSH_WORDS, go to RUN.
    - A new redirect during FLUSH restarts the count to 0 at the next word_end and pulses o_sync_sqi_redirect again.
    - Stall is ignored in FLUSH.
- Redirect pending: set by i_sync_redirect in any state; cleared on FLUSH entry. A redirect arriving on the same cycle as the entry word_end is consumed by that entry, not kept pending.
- Stage valid:
  - On word_end in RUN: stage_vld <= {stage_vld[NUM_STAGES-2:0], i_sync_instr_vld}. For NUM_STAGES = 1, stage_vld <= i_sync_instr_vld.
  - Cleared to 0 on FLUSH entry and held at 0 throughout FLUSH and INIT.
  - Holds its value in STALL.

Decomposition:
- idli_pkg additions:
  - SLICES and CTR_W derived from the package DATA_W/SLICE_W;
  - ctr_t redefined as logic [CTR_W-1:0];
  - sync_state_t enum.
- Sub-module: idli_sync_ctr_m, a slice counter with advance enable, first/last/word_end decode and a word counter with load/clear. Instantiated once here; SQI reuses it later.

Test Plan:
- Reset, defaults (SLICES = 4, INIT_WORDS = 2): release reset → run = 0 for 8 cycles, ctr sequence 0,1,2,3,0,1,2,3; run = 1 from cycle 8; word_end on cycles 3 and 7.
- Stall: hold i_sync_stall = 1 from ctr = 1 of a RUN word → ctr reaches 3 then holds at 0 with run = 0. Drop stall for one cycle → ctr = 1 next cycle, run = 1, stage_vld unchanged.
- Redirect: pulse redirect at ctr = 1 with stage_vld = 2'b11 → at word_end stage_vld = 0 and state FLUSH; sqi_redirect is high for exactly the ctr = 0 cycle; RUN resumes after 4 cycles.
- Simultaneous: redirect and stall both high on ctr = 3 in RUN → FLUSH entered, STALL not entered, pending = 0 afterwards.
- Redirect during INIT word 0 → after INIT completes, FLUSH is entered directly; run stays 0 for an extra 4 cycles.
- Parametric: DATA_W = 16, SLICE_W = 2, NUM_STAGES = 3 → ctr wraps at 7; instr_vld pattern 1,0,1 shifts to stage_vld = 3'b101 after three words; reset asserted at ctr = 5 → ctr = 0 and state INIT immediately.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and default geometry for the idli core.
package idli_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SLICE_W = 4;
    localparam int unsigned SLICES  = DATA_W / SLICE_W;
    localparam int unsigned CTR_W   = $clog2(SLICES);

    typedef logic [CTR_W-1:0] ctr_t;

    typedef enum logic [1:0] {
        SyncInit,
        SyncRun,
        SyncStall,
        SyncFlush
    } sync_state_t;

endpackage

// File: rtl/idli_sync_ctr_m.sv
// Slice counter with advance enable, slice decode and a clearable word counter.
module idli_sync_ctr_m
    import idli_pkg::*;
#(
    parameter int unsigned NUM_SLICES = 4,
    parameter int unsigned CTR_W      = $clog2(NUM_SLICES),
    parameter int unsigned WCNT_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_adv,
    input  logic              i_wcnt_clr,
    input  logic              i_wcnt_inc,
    output logic [CTR_W-1:0]  o_ctr,
    output logic              o_first,
    output logic              o_last,
    output logic              o_word_end,
    output logic [WCNT_W-1:0] o_wcnt
);

    localparam logic [CTR_W-1:0] LastCtr = CTR_W'(NUM_SLICES - 1);

    logic [CTR_W-1:0]  ctr_q, ctr_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        ctr_d = ctr_q;
        if (i_adv) begin
            ctr_d = (ctr_q == LastCtr) ? '0 : ctr_q + 1'b1;
        end

        // Clear wins over increment so a terminal word_end lands on zero.
        wcnt_d = wcnt_q;
        if (i_wcnt_clr) begin
            wcnt_d = '0;
        end else if (i_wcnt_inc) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctr_q  <= '0;
            wcnt_q <= '0;
        end else begin
            ctr_q  <= ctr_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign o_ctr      = ctr_q;
    assign o_first    = (ctr_q == '0);
    assign o_last     = (ctr_q == LastCtr);
    assign o_word_end = o_last && i_adv;
    assign o_wcnt     = wcnt_q;

endmodule

// File: rtl/idli_sync_m.sv
// Core sync/control: slice sequencing with post-reset warm-up, word-boundary
// stall and redirect flush, plus the per-stage instruction valid pipeline.
module idli_sync_m
    import idli_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SLICE_W     = 4,
    parameter int unsigned INIT_WORDS  = 2,
    parameter int unsigned FLUSH_WORDS = 1,
    parameter int unsigned NUM_STAGES  = 2
) (
    input  logic                                  i_sync_gck,
    input  logic                                  i_sync_rst_n,
    input  logic                                  i_sync_stall,
    input  logic                                  i_sync_redirect,
    input  logic                                  i_sync_instr_vld,
    output logic [$clog2(DATA_W/SLICE_W)-1:0]     o_sync_ctr,
    output logic                                  o_sync_first,
    output logic                                  o_sync_last,
    output logic                                  o_sync_word_end,
    output logic                                  o_sync_run,
    output logic                                  o_sync_sqi_redirect,
    output logic [NUM_STAGES-1:0]                 o_sync_stage_vld
);

    localparam int unsigned NSLICES   = DATA_W / SLICE_W;
    localparam int unsigned CW        = $clog2(NSLICES);
    localparam int unsigned WORDS_MAX = (INIT_WORDS > FLUSH_WORDS) ? INIT_WORDS : FLUSH_WORDS;
    localparam int unsigned WCNT_W    = $clog2(WORDS_MAX + 1);

    sync_state_t           state_q;
    logic                  pend_q;
    logic [NUM_STAGES-1:0] stage_vld_q;
    logic [NUM_STAGES-1:0] vld_shift;

    logic              adv, first, last, word_end;
    logic [WCNT_W-1:0] wcnt;
    logic              pend_eff, init_done, flush_done, enter_flush;
    logic              wcnt_clr, wcnt_inc;

    idli_sync_ctr_m #(
        .NUM_SLICES (NSLICES),
        .CTR_W      (CW),
        .WCNT_W     (WCNT_W)
    ) u_ctr (
        .i_clk      (i_sync_gck),
        .i_rst_n    (i_sync_rst_n),
        .i_adv      (adv),
        .i_wcnt_clr (wcnt_clr),
        .i_wcnt_inc (wcnt_inc),
        .o_ctr      (o_sync_ctr),
        .o_first    (first),
        .o_last     (last),
        .o_word_end (word_end),
        .o_wcnt     (wcnt)
    );

    if (NUM_STAGES == 1) begin : g_vld_one
        assign vld_shift = i_sync_instr_vld;
    end else begin : g_vld_many
        assign vld_shift = {stage_vld_q[NUM_STAGES-2:0], i_sync_instr_vld};
    end

    always_comb begin
        adv         = (state_q != SyncStall) || !i_sync_stall;
        // A redirect on the deciding word_end counts as already pending.
        pend_eff    = pend_q || i_sync_redirect;
        init_done   = (wcnt == WCNT_W'(INIT_WORDS - 1));
        flush_done  = (wcnt == WCNT_W'(FLUSH_WORDS - 1));
        enter_flush = 1'b0;
        wcnt_clr    = 1'b0;
        wcnt_inc    = 1'b0;
        if (word_end) begin
            case (state_q)
                SyncInit: begin
                    wcnt_inc = 1'b1;
                    if (init_done) begin
                        wcnt_clr    = 1'b1;
                        enter_flush = pend_eff;
                    end
                end
                SyncRun: begin
                    enter_flush = pend_eff;
                end
                SyncFlush: begin
                    wcnt_inc    = 1'b1;
                    enter_flush = pend_eff;
                    wcnt_clr    = flush_done;
                end
                default: ;
            endcase
            if (enter_flush) begin
                wcnt_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge i_sync_gck or negedge i_sync_rst_n) begin
        if (!i_sync_rst_n) begin
            state_q     <= SyncInit;
            pend_q      <= 1'b0;
            stage_vld_q <= '0;
        end else begin
            pend_q <= enter_flush ? 1'b0 : pend_eff;
            case (state_q)
                SyncInit: begin
                    if (word_end && init_done) begin
                        state_q <= pend_eff ? SyncFlush : SyncRun;
                    end
                end
                SyncRun: begin
                    if (word_end) begin
                        if (pend_eff) begin
                            state_q     <= SyncFlush;
                            stage_vld_q <= '0;
                        end else begin
                            stage_vld_q <= vld_shift;
                            if (i_sync_stall) begin
                                state_q <= SyncStall;
                            end
                        end
                    end
                end
                SyncStall: begin
                    if (!i_sync_stall) begin
                        state_q <= SyncRun;
                    end
                end
                SyncFlush: begin
                    if (word_end && !pend_eff && flush_done) begin
                        state_q <= SyncRun;
                    end
                end
                default: state_q <= SyncInit;
            endcase
        end
    end

    assign o_sync_first        = first;
    assign o_sync_last         = last;
    assign o_sync_word_end     = word_end;
    assign o_sync_run          = (state_q == SyncRun);
    assign o_sync_sqi_redirect = (state_q == SyncFlush) && first && (wcnt == '0);
    assign o_sync_stage_vld    = stage_vld_q;

endmodule

// File: tb/tb_idli_sync_m.sv
// Directed bench for idli_sync_m: default geometry plus an 8-slice, 3-stage build.
module tb_idli_sync_m;

    logic       clk;
    logic       rst_n, stall, redirect, instr_vld;
    logic [1:0] ctr;
    logic       first, last, word_end, run, sqi;
    logic [1:0] vld;

    logic       rst_p_n, stall_p, redir_p, instr_p;
    logic [2:0] ctr_p;
    logic       first_p, last_p, we_p, run_p, sqi_p;
    logic [2:0] vld_p;

    int n_vec = 0;
    int n_err = 0;

    idli_sync_m u_dut (
        .i_sync_gck          (clk),
        .i_sync_rst_n        (rst_n),
        .i_sync_stall        (stall),
        .i_sync_redirect     (redirect),
        .i_sync_instr_vld    (instr_vld),
        .o_sync_ctr          (ctr),
        .o_sync_first        (first),
        .o_sync_last         (last),
        .o_sync_word_end     (word_end),
        .o_sync_run          (run),
        .o_sync_sqi_redirect (sqi),
        .o_sync_stage_vld    (vld)
    );

    idli_sync_m #(
        .DATA_W      (16),
        .SLICE_W     (2),
        .INIT_WORDS  (2),
        .FLUSH_WORDS (1),
        .NUM_STAGES  (3)
    ) u_dut_p (
        .i_sync_gck          (clk),
        .i_sync_rst_n        (rst_p_n),
        .i_sync_stall        (stall_p),
        .i_sync_redirect     (redir_p),
        .i_sync_instr_vld    (instr_p),
        .o_sync_ctr          (ctr_p),
        .o_sync_first        (first_p),
        .o_sync_last         (last_p),
        .o_sync_word_end     (we_p),
        .o_sync_run          (run_p),
        .o_sync_sqi_redirect (sqi_p),
        .o_sync_stage_vld    (vld_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; instr_vld = 1'b1;
        rst_p_n = 1'b0; stall_p = 1'b0; redir_p = 1'b0; instr_p = 1'b0;
        repeat (3) step();

        check_eq("rst_ctr", 32'(ctr), 0);
        check_eq("rst_first", 32'(first), 1);
        check_eq("rst_last", 32'(last), 0);
        check_eq("rst_we", 32'(word_end), 0);
        check_eq("rst_run", 32'(run), 0);
        check_eq("rst_sqi", 32'(sqi), 0);
        check_eq("rst_vld", 32'(vld), 0);

        // Cycle 0 starts at reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("init_ctr%0d", i), 32'(ctr), 32'(i % 4));
            check_eq($sformatf("init_run%0d", i), 32'(run), 0);
            check_eq($sformatf("init_we%0d", i), 32'(word_end), 32'(i % 4 == 3));
            step();
        end
        check_eq("run_c8", 32'(run), 1);
        check_eq("ctr_c8", 32'(ctr), 0);
        check_eq("vld_c8", 32'(vld), 0);
        repeat (4) step();
        check_eq("vld_c12", 32'(vld), 32'h1);
        repeat (4) step();
        check_eq("vld_c16", 32'(vld), 32'h3);

        // Stall raised at ctr = 1; last shift brings in a 0.
        step();
        stall = 1'b1; instr_vld = 1'b0;
        step(); step();
        check_eq("stall_ctr3", 32'(ctr), 3);
        check_eq("stall_we3", 32'(word_end), 1);
        check_eq("stall_run3", 32'(run), 1);
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("stall_ctr_h%0d", i), 32'(ctr), 0);
            check_eq($sformatf("stall_run_h%0d", i), 32'(run), 0);
            check_eq($sformatf("stall_vld_h%0d", i), 32'(vld), 32'h2);
            check_eq($sformatf("stall_we_h%0d", i), 32'(word_end), 0);
            if (i < 2) step();
        end
        stall = 1'b0;
        step();
        check_eq("rel_ctr", 32'(ctr), 1);
        check_eq("rel_run", 32'(run), 1);
        check_eq("rel_vld", 32'(vld), 32'h2);

        // Refill to 2'b11, then redirect at ctr = 1.
        instr_vld = 1'b1;
        repeat (7) step();
        check_eq("pre_redir_vld", 32'(vld), 32'h3);
        check_eq("pre_redir_ctr", 32'(ctr), 0);
        step();
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        step();
        check_eq("redir_ctr3", 32'(ctr), 3);
        check_eq("redir_we", 32'(word_end), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("flush_run%0d", i), 32'(run), 0);
            check_eq($sformatf("flush_vld%0d", i), 32'(vld), 0);
            check_eq($sformatf("flush_ctr%0d", i), 32'(ctr), 32'(i));
            check_eq($sformatf("flush_sqi%0d", i), 32'(sqi), 32'(i == 0));
            step();
        end
        check_eq("post_flush_run", 32'(run), 1);
        check_eq("post_flush_ctr", 32'(ctr), 0);

        // Redirect and stall together on the last slice.
        repeat (3) step();
        check_eq("sim_ctr3", 32'(ctr), 3);
        redirect = 1'b1; stall = 1'b1;
        step();
        redirect = 1'b0;
        check_eq("sim_run", 32'(run), 0);
        check_eq("sim_ctr0", 32'(ctr), 0);
        check_eq("sim_sqi", 32'(sqi), 1);
        step();
        check_eq("sim_ctr1", 32'(ctr), 1);
        check_eq("sim_run1", 32'(run), 0);
        step(); step();
        check_eq("sim_ctr3b", 32'(ctr), 3);
        check_eq("sim_we", 32'(word_end), 1);
        stall = 1'b0;
        step();
        check_eq("sim_back_run", 32'(run), 1);
        check_eq("sim_back_ctr", 32'(ctr), 0);
        repeat (4) step();
        check_eq("sim_nopend_run", 32'(run), 1);
        check_eq("sim_nopend_sqi", 32'(sqi), 0);

        // Asynchronous reset mid-word.
        step(); step();
        check_eq("mid_ctr2", 32'(ctr), 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_ctr", 32'(ctr), 0);
        check_eq("arst_run", 32'(run), 0);
        check_eq("arst_first", 32'(first), 1);

        // Redirect during INIT word 0 goes straight to FLUSH.
        step();
        rst_n = 1'b1;
        step();
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        repeat (5) step();
        check_eq("iredir_run7", 32'(run), 0);
        check_eq("iredir_we7", 32'(word_end), 1);
        step();
        check_eq("iredir_run8", 32'(run), 0);
        check_eq("iredir_sqi8", 32'(sqi), 1);
        check_eq("iredir_ctr8", 32'(ctr), 0);
        repeat (3) step();
        check_eq("iredir_run11", 32'(run), 0);
        check_eq("iredir_ctr11", 32'(ctr), 3);
        step();
        check_eq("iredir_run12", 32'(run), 1);
        check_eq("iredir_ctr12", 32'(ctr), 0);

        // 8-slice, 3-stage build.
        rst_p_n = 1'b1; instr_p = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("p_ctr%0d", i), 32'(ctr_p), 32'(i % 8));
            check_eq($sformatf("p_we%0d", i), 32'(we_p), 32'(i % 8 == 7));
            check_eq($sformatf("p_run%0d", i), 32'(run_p), 0);
            step();
        end
        check_eq("p_run16", 32'(run_p), 1);
        check_eq("p_ctr16", 32'(ctr_p), 0);
        repeat (8) step();
        check_eq("p_vld_w0", 32'(vld_p), 32'h1);
        instr_p = 1'b0;
        repeat (8) step();
        check_eq("p_vld_w1", 32'(vld_p), 32'h2);
        instr_p = 1'b1;
        repeat (8) step();
        check_eq("p_vld_w2", 32'(vld_p), 32'h5);
        repeat (5) step();
        check_eq("p_ctr5", 32'(ctr_p), 5);
        check_eq("p_sqi", 32'(sqi_p), 0);
        #2 rst_p_n = 1'b0;
        #1;
        check_eq("p_arst_ctr", 32'(ctr_p), 0);
        check_eq("p_arst_run", 32'(run_p), 0);
        check_eq("p_arst_vld", 32'(vld_p), 0);
        check_eq("p_arst_first", 32'(first_p), 1);
        check_eq("p_arst_last", 32'(last_p), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
